note_tone_gen: RTL



---
 rtl/note_tone_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: octave/note pair -> half-period from a 12-entry
// octave-0 table shifted by octave, toggling tone_out every half period.
module note_tone_gen #(
    parameter int SIM_SHIFT = 0,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       gate,
    input  logic       note_valid,
    output logic       note_ready,
    input  logic [2:0] octave,
    input  logic [3:0] note,
    output logic       tone_out,
    output logic       active,
    output logic       bad_note
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       oct_q, oct_d;
    logic [3:0]       note_q, note_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;
    logic             active_q, active_d;
    logic             bad_q, bad_d;

    logic [19:0]      base;
    logic [CNT_W-1:0] hp_new;
    logic             illegal;
    logic             accept;

    // Octave-0 half periods in 100 MHz clocks, C2..B2
    always_comb begin
        case (note_q)
            4'd0:    base = 20'd764451;
            4'd1:    base = 20'd721546;
            4'd2:    base = 20'd681049;
            4'd3:    base = 20'd642824;
            4'd4:    base = 20'd606745;
            4'd5:    base = 20'd572691;
            4'd6:    base = 20'd540549;
            4'd7:    base = 20'd510210;
            4'd8:    base = 20'd481574;
            4'd9:    base = 20'd454545;
            4'd10:   base = 20'd429034;
            4'd11:   base = 20'd404956;
            default: base = 20'd0;
        endcase
    end

    assign hp_new     = CNT_W'((base >> oct_q) >> SIM_SHIFT);
    assign illegal    = (note_q >= 4'd12) || (oct_q > 3'd5);
    assign note_ready = gate && (state_q != LOAD);
    assign accept     = note_valid && note_ready;

    always_comb begin
        state_d  = state_q;
        oct_d    = oct_q;
        note_d   = note_q;
        hp_d     = hp_q;
        cnt_d    = cnt_q;
        tone_d   = tone_q;
        active_d = active_q;
        bad_d    = bad_q;
        case (state_q)
            IDLE: begin
                tone_d   = 1'b0;
                active_d = 1'b0;
                if (accept) begin
                    state_d = LOAD;
                    oct_d   = octave;
                    note_d  = note;
                end
            end
            LOAD: begin
                tone_d = 1'b0;
                if (illegal) begin
                    bad_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    bad_d    = 1'b0;
                    hp_d     = hp_new;
                    cnt_d    = hp_new - CNT_W'(1);
                    active_d = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (!gate) begin
                    tone_d   = 1'b0;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end else if (accept) begin
                    // New note restarts the waveform from low; no phase carry-over
                    tone_d  = 1'b0;
                    oct_d   = octave;
                    note_d  = note;
                    state_d = LOAD;
                end else if (cnt_q == '0) begin
                    tone_d = ~tone_q;
                    cnt_d  = hp_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                tone_d   = 1'b0;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            oct_q    <= '0;
            note_q   <= '0;
            hp_q     <= '0;
            cnt_q    <= '0;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            oct_q    <= oct_d;
            note_q   <= note_d;
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            tone_q   <= tone_d;
            active_q <= active_d;
            bad_q    <= bad_d;
        end
    end

    assign tone_out = tone_q;
    assign active   = active_q;
    assign bad_note = bad_q;

endmodule
